// File: rtl/ram_reader.sv
// ram_reader: streams COUNT consecutive RAM words starting at BASE_ADDR out
// of the RAM read port (addrb/doutb) over a valid/ready interface.
// Read latency and downstream backpressure are absorbed by a small FIFO.
// Reads are issued only while FIFO occupancy plus reads still in flight
// leaves room, so the FIFO can never overflow.
// Optional build macro RAM_READER_CHK_EN adds a running checksum output
// (sum of all popped words, modulo 2^DATA_W).
module ram_reader #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,      // active-high synchronous reset
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrb,
  output logic              rd_en,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef RAM_READER_CHK_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = OCC_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    popped_q, popped_d;
  logic [RD_LAT-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [OCC_W-1:0]    inflight;
  logic                credit;
  logic                push;
  logic                pop;
`ifdef RAM_READER_CHK_EN
  logic [DATA_W-1:0]   chk_q, chk_d;
`endif

  // Next-state, read issue, return capture, FIFO bookkeeping and outputs.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    issued_d = issued_q;
    popped_d = popped_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    rd_en    = 1'b0;

    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(lat_q[i]);
    end
    credit = ({1'b0, occ_q} + {1'b0, inflight}) < SUM_W'(FIFO_DEPTH);

    out_valid = (occ_q != '0);
    out_data  = mem_q[rd_ptr_q];
    out_last  = out_valid && (popped_q == count_q - CNT_W'(1));
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    addrb     = base_q + ADDR_W'(issued_q);

    push = lat_q[RD_LAT-1];
    pop  = out_valid && out_ready;

    if (pop) begin
      popped_d = popped_q + CNT_W'(1);
    end

`ifdef RAM_READER_CHK_EN
    chk_d = chk_q;
    if (pop) begin
      chk_d = chk_q + out_data;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          count_d  = count;
          issued_d = '0;
          popped_d = '0;
`ifdef RAM_READER_CHK_EN
          chk_d    = '0;
`endif
          state_d  = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (credit) begin
          rd_en    = 1'b1;
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (popped_q == count_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Read-return shift register: a 1 leaving the end marks doutb as valid.
    lat_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end

    if (push) begin
      mem_d[wr_ptr_q] = doutb;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State register; reset discards in-flight reads and buffered words.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      popped_q <= '0;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef RAM_READER_CHK_EN
      chk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      lat_q    <= lat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
`ifdef RAM_READER_CHK_EN
      chk_q    <= chk_d;
`endif
    end
  end

`ifdef RAM_READER_CHK_EN
  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: basic burst, backpressure with credit
// limiting, zero count, address wrap with an ignored mid-burst start,
// reset mid-burst, and (with RAM_READER_CHK_EN) the checksum.
module tb_ram_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0;
  logic        busy, done, rd_en, out_valid, out_last;
  logic [31:0] addrb, out_data;
  logic [31:0] doutb = '0;
  logic        out_ready = 1'b1;
`ifdef RAM_READER_CHK_EN
  logic [31:0] checksum;
  logic [31:0] chk_at_done;
`endif

  ram_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .addrb(addrb), .rd_en(rd_en),
    .doutb(doutb), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
`ifdef RAM_READER_CHK_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM model, RD_LAT = 1, indexed by the low address byte.
  logic [31:0] ram [256];
  always @(posedge clk) if (rd_en) doutb <= ram[addrb[7:0]];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor state, sampled on the falling edge.
  int          cyc = 0;
  int          start_cyc, done_cyc, done_cnt, max_out;
  logic [31:0] addr_q[$];
  int          rd_cyc[$];
  logic [31:0] data_q[$];
  logic        last_q[$];
  int          beat_cyc[$];
  logic        valid_seen;
  logic        held_v = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic [31:0] exp_d [8];

  always @(negedge clk) begin
    if (!rst_n) begin
      if (start && !busy && !done) start_cyc = cyc;
      if (rd_en) begin addr_q.push_back(addrb); rd_cyc.push_back(cyc); end
      if (out_valid) valid_seen = 1'b1;
      if (held_v) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, held_data);
        check_eq("hold_last", out_last, held_last);
      end
      held_v    = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        data_q.push_back(out_data); last_q.push_back(out_last); beat_cyc.push_back(cyc);
      end
      if (addr_q.size() - data_q.size() > max_out) max_out = addr_q.size() - data_q.size();
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef RAM_READER_CHK_EN
        chk_at_done = checksum;
`endif
      end
    end else begin
      held_v = 1'b0;
    end
    cyc++;
  end

  task automatic clear_mon();
    addr_q.delete(); rd_cyc.delete(); data_q.delete(); last_q.delete(); beat_cyc.delete();
    done_cnt = 0; max_out = 0; valid_seen = 1'b0; start_cyc = -100; done_cyc = -100;
  endtask

  // One burst: cycle i=0 carries start; out_ready is low for cycles rlo..rhi;
  // a second start (different base/count) is pulsed at cycle rs_at.
  task automatic run(input logic [31:0] base, input logic [15:0] cnt,
                     input int rlo, input int rhi, input int rs_at);
    int tail;
    tail = -1;
    clear_mon();
    @(posedge clk); #2;
    base_addr = base; count = cnt; start = 1'b1; out_ready = 1'b1;
    for (int i = 1; i < 150 && tail != 0; i++) begin
      @(posedge clk); #2;
      start = (i == rs_at);
      if (i == rs_at) begin base_addr = 32'h5555_0000; count = 16'd9; end
      out_ready = !(i >= rlo && i <= rhi);
      if (tail > 0) tail--;
      else if (tail < 0 && done_cnt > 0) tail = 3;
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_burst(input string nm, input int cnt, input logic [31:0] a0);
    logic [31:0] a;
    check_eq({nm, "_nrd"}, addr_q.size(), cnt);
    check_eq({nm, "_nbeat"}, data_q.size(), cnt);
    check_eq({nm, "_done_pulses"}, done_cnt, 1);
    for (int i = 0; i < cnt && i < addr_q.size(); i++) begin
      a = a0 + 32'(i);
      check_eq({nm, "_addr"}, addr_q[i], a);
    end
    for (int i = 0; i < cnt && i < data_q.size(); i++) begin
      check_eq({nm, "_data"}, data_q[i], exp_d[i]);
      check_eq({nm, "_last"}, last_q[i], (i == cnt - 1));
    end
    if (data_q.size() > 0) check_eq({nm, "_done_after_last"}, done_cyc - beat_cyc[data_q.size()-1], 2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_addrb", addrb, 0);
    check_eq("rst_data", out_data, 0);

    // Basic burst, out_ready held high.
    for (int i = 0; i < 6; i++) ram[8'h10 + i] = 32'hA + 32'(i);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA + 32'(i);
    run(32'h10, 16'd4, -1, -1, -1);
    check_burst("basic", 4, 32'h10);
    if (rd_cyc.size() == 4 && beat_cyc.size() == 4) begin
      check_eq("basic_rd0_cyc", rd_cyc[0] - start_cyc, 1);
      check_eq("basic_rd3_cyc", rd_cyc[3] - start_cyc, 4);
      check_eq("basic_beat0_cyc", beat_cyc[0] - start_cyc, 3);
      check_eq("basic_beat3_cyc", beat_cyc[3] - start_cyc, 6);
    end else check_eq("basic_timing_sizes", rd_cyc.size() + beat_cyc.size(), 8);
    check_eq("basic_idle_busy", busy, 0);

    // Same 4-word burst with out_ready low for cycles 3-8.
    run(32'h10, 16'd4, 3, 8, -1);
    check_burst("bp4", 4, 32'h10);
    check_eq("bp4_first_beat", beat_cyc.size() > 0 ? beat_cyc[0] - start_cyc : -1, 9);

    // Six words under the same stall: reads stop once 4 are outstanding.
    for (int i = 0; i < 6; i++) exp_d[i] = 32'hA + 32'(i);
    run(32'h10, 16'd6, 3, 8, -1);
    check_burst("bp6", 6, 32'h10);
    check_eq("bp6_max_outstanding", max_out, 4);

    // Zero count: done pulse, no reads, no beats.
    run(32'h40, 16'd0, -1, -1, -1);
    check_eq("zero_nrd", addr_q.size(), 0);
    check_eq("zero_valid_seen", valid_seen, 0);
    check_eq("zero_done_pulses", done_cnt, 1);
    check_eq("zero_done_delay_ok", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);

    // Address wrap, with a second start pulsed mid-burst.
    ram[8'hFE] = 32'h111; ram[8'hFF] = 32'h222; ram[8'h00] = 32'h333;
    exp_d[0] = 32'h111; exp_d[1] = 32'h222; exp_d[2] = 32'h333;
    run(32'hFFFF_FFFE, 16'd3, -1, -1, 2);
    check_burst("wrap", 3, 32'hFFFF_FFFE);

    // Reset during RUN of an 8-word burst.
    for (int i = 0; i < 8; i++) ram[8'h20 + i] = 32'h100 + 32'(i);
    clear_mon();
    @(posedge clk); #2;
    base_addr = 32'h20; count = 16'd8; start = 1'b1;
    repeat (3) begin @(posedge clk); #2; start = 1'b0; end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_rd_en", rd_en, 0);
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_addrb", addrb, 0);
    rst_n = 1'b0;
    clear_mon();
    repeat (20) @(posedge clk);
    #2;
    check_eq("mrst_no_reads", addr_q.size(), 0);
    check_eq("mrst_no_beats", data_q.size(), 0);
    check_eq("mrst_no_done", done_cnt, 0);

    // Three words whose sum wraps: 1 + 2 + 0xFFFFFFFF = 2 (mod 2^32).
    ram[8'h30] = 32'h1; ram[8'h31] = 32'h2; ram[8'h32] = 32'hFFFF_FFFF;
    exp_d[0] = 32'h1; exp_d[1] = 32'h2; exp_d[2] = 32'hFFFF_FFFF;
    run(32'h30, 16'd3, -1, -1, -1);
    check_burst("sum", 3, 32'h30);
`ifdef RAM_READER_CHK_EN
    check_eq("chk_at_done", chk_at_done, 32'h2);
    check_eq("chk_held", checksum, 32'h2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
